// File: rtl/gb_frame_blend_pkg.sv
// Shared types and blend arithmetic for the gb_frame_blend LCD ghosting stage.
// Used by both the default (raw history) and GB_FRAME_BLEND_ACCUM_EN (blended history) builds.
package gb_frame_blend_pkg;

    localparam int DEFAULT_ADDR_W = 16;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_HALF   = 2'd1,
        MODE_LIGHT  = 2'd2,
        MODE_HEAVY  = 2'd3
    } blend_mode_e;

    typedef enum logic [1:0] {
        HIST_EMPTY   = 2'd0,
        HIST_FILLING = 2'd1,
        HIST_VALID   = 2'd2
    } hist_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    typedef struct packed {
        logic    ce;
        logic    hs;
        logic    vs;
        logic    hbl;
        logic    vbl;
        rgb888_t rgb;
    } vid_t;

    localparam vid_t VID_RESET = '{ce: 1'b0, hs: 1'b0, vs: 1'b0, hbl: 1'b1, vbl: 1'b1, rgb: '0};

    // c = current pixel, p = previous frame; 10-bit intermediates keep 3*255+255+2 exact.
    function automatic logic [7:0] blend_ch(input blend_mode_e mode, input logic [7:0] c,
                                            input logic [7:0] p);
        logic [9:0] c10;
        logic [9:0] p10;
        c10 = {2'b00, c};
        p10 = {2'b00, p};
        case (mode)
            MODE_HALF:  return 8'((c10 + p10 + 10'd1) >> 1);
            MODE_LIGHT: return 8'((10'd3 * c10 + p10 + 10'd2) >> 2);
            MODE_HEAVY: return 8'((c10 + 10'd3 * p10 + 10'd2) >> 2);
            default:    return c;
        endcase
    endfunction

endpackage

// File: rtl/gb_frame_blend_ram.sv
// Simple dual-port frame history RAM, 24-bit RGB words, one-cycle registered read.
// Read-during-write to the same address returns the old word.
module gb_frame_blend_ram
    import gb_frame_blend_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [23:0]       wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [23:0]       rdata_o
);

    logic [23:0] mem_q [2**ADDR_W];
    logic [23:0] rdata_q;

    // NOTE: no reset on the array or read register so the tools can map this onto block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/gb_frame_blend.sv
// Blends each active LCD pixel with the co-located pixel of the previous frame (2-clock latency).
// GB_FRAME_BLEND_ACCUM_EN: history keeps the blended output (IIR); otherwise it keeps raw pixels.
module gb_frame_blend
    import gb_frame_blend_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic       clk_vid,
    input  logic       reset,
    input  logic [1:0] blend_mode,
    input  logic       ce_pix_in,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic       hbl_in,
    input  logic       vbl_in,
    input  logic [7:0] r_in,
    input  logic [7:0] g_in,
    input  logic [7:0] b_in,
    output logic       ce_pix,
    output logic       hs,
    output logic       vs,
    output logic       hbl,
    output logic       vbl,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ovf_q, ovf_d;
    logic              bypass_seen_q, bypass_seen_d;
    logic              vbl_prev_q;
    hist_e             hist_q, hist_d;
    logic              blend_en;

    vid_t              s1_vid_q;
    logic              s1_act_q;
    logic              s1_we_q;
    logic [ADDR_W-1:0] s1_addr_q;
    blend_mode_e       s1_mode_q;
    logic              s1_blend_en_q;

    vid_t              out_vid_q;
    rgb888_t           ram_rdata;
    rgb888_t           blended;
    rgb888_t           wr_data;

    logic pix_act;
    logic vbl_rise;

    assign pix_act  = ce_pix_in & ~hbl_in & ~vbl_in;
    assign vbl_rise = vbl_in & ~vbl_prev_q;

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        addr_d        = addr_q;
        ovf_d         = ovf_q;
        bypass_seen_d = bypass_seen_q;
        if (vbl_in) begin
            addr_d        = '0;
            ovf_d         = 1'b0;
            bypass_seen_d = 1'b0;
        end else if (pix_act) begin
            if (addr_q == ADDR_MAX) begin
                ovf_d = 1'b1;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
            if (blend_mode == MODE_BYPASS) begin
                bypass_seen_d = 1'b1;
            end
        end
    end

    // History FSM: state register, next-state logic, output decode.
    always_ff @(posedge clk_vid) begin
        if (reset) begin
            hist_q <= HIST_EMPTY;
        end else begin
            hist_q <= hist_d;
        end
    end

    always_comb begin
        hist_d = hist_q;
        case (hist_q)
            HIST_EMPTY:   if (pix_act) hist_d = HIST_FILLING;
            HIST_FILLING: if (vbl_rise) hist_d = ovf_q ? HIST_EMPTY : HIST_VALID;
            HIST_VALID:   if (vbl_rise && (ovf_q || bypass_seen_q)) hist_d = HIST_EMPTY;
            default:      hist_d = HIST_EMPTY;
        endcase
    end

    always_comb begin
        blend_en = (hist_q == HIST_VALID);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_vid) begin
        if (reset) begin
            addr_q        <= '0;
            ovf_q         <= 1'b0;
            bypass_seen_q <= 1'b0;
            vbl_prev_q    <= 1'b1;
            s1_vid_q      <= VID_RESET;
            s1_act_q      <= 1'b0;
            s1_we_q       <= 1'b0;
            s1_addr_q     <= '0;
            s1_mode_q     <= MODE_BYPASS;
            s1_blend_en_q <= 1'b0;
            out_vid_q     <= VID_RESET;
        end else begin
            addr_q        <= addr_d;
            ovf_q         <= ovf_d;
            bypass_seen_q <= bypass_seen_d;
            vbl_prev_q    <= vbl_in;
            s1_vid_q      <= '{ce: ce_pix_in, hs: hs_in, vs: vs_in, hbl: hbl_in, vbl: vbl_in,
                               rgb: '{r: r_in, g: g_in, b: b_in}};
            s1_act_q      <= pix_act;
            s1_we_q       <= pix_act & ~ovf_q;
            s1_addr_q     <= addr_q;
            s1_mode_q     <= blend_mode_e'(blend_mode);
            s1_blend_en_q <= blend_en;
            out_vid_q     <= '{ce: s1_vid_q.ce, hs: s1_vid_q.hs, vs: s1_vid_q.vs,
                               hbl: s1_vid_q.hbl, vbl: s1_vid_q.vbl, rgb: blended};
        end
    end

    always_comb begin
        blended = s1_vid_q.rgb;
        if (s1_act_q && s1_blend_en_q) begin
            blended.r = blend_ch(s1_mode_q, s1_vid_q.rgb.r, ram_rdata.r);
            blended.g = blend_ch(s1_mode_q, s1_vid_q.rgb.g, ram_rdata.g);
            blended.b = blend_ch(s1_mode_q, s1_vid_q.rgb.b, ram_rdata.b);
        end
    end

`ifdef GB_FRAME_BLEND_ACCUM_EN
    assign wr_data = blended;
`else
    assign wr_data = s1_vid_q.rgb;
`endif

    gb_frame_blend_ram #(
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk_i  (clk_vid),
        .we_i   (s1_we_q),
        .waddr_i(s1_addr_q),
        .wdata_i(wr_data),
        .raddr_i(addr_q),
        .rdata_o(ram_rdata)
    );

    assign ce_pix = out_vid_q.ce;
    assign hs     = out_vid_q.hs;
    assign vs     = out_vid_q.vs;
    assign hbl    = out_vid_q.hbl;
    assign vbl    = out_vid_q.vbl;
    assign r      = out_vid_q.rgb.r;
    assign g      = out_vid_q.rgb.g;
    assign b      = out_vid_q.rgb.b;

endmodule

// File: tb/tb_gb_frame_blend.sv
// Directed bench for gb_frame_blend: small frames, expected outputs tracked through a 2-deep queue.
// Expected colours follow the build (GB_FRAME_BLEND_ACCUM_EN selects the IIR values).
module tb_gb_frame_blend;
    import gb_frame_blend_pkg::*;

    localparam int W = 8;
    localparam int H = 4;
    localparam logic [23:0] BLANK_RGB = 24'h123456;
    localparam logic [28:0] RST_V = {5'b00011, 24'h000000};

    typedef struct {
        logic [28:0] v;
        bit          dc;
    } exp_t;

    logic       clk_vid = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] blend_mode = 2'd0;
    logic       ce_pix_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0, hbl_in = 1'b1, vbl_in = 1'b1;
    logic [7:0] r_in = 8'h00, g_in = 8'h00, b_in = 8'h00;
    logic       ce_pix, hs, vs, hbl, vbl;
    logic [7:0] r, g, b;

    int    checks = 0;
    int    failures = 0;
    string phase = "reset";
    exp_t  pipe[$];

    gb_frame_blend dut (
        .clk_vid   (clk_vid),
        .reset     (reset),
        .blend_mode(blend_mode),
        .ce_pix_in (ce_pix_in),
        .hs_in     (hs_in),
        .vs_in     (vs_in),
        .hbl_in    (hbl_in),
        .vbl_in    (vbl_in),
        .r_in      (r_in),
        .g_in      (g_in),
        .b_in      (b_in),
        .ce_pix    (ce_pix),
        .hs        (hs),
        .vs        (vs),
        .hbl       (hbl),
        .vbl       (vbl),
        .r         (r),
        .g         (g),
        .b         (b)
    );

    always #5 clk_vid = ~clk_vid;

    function automatic logic [28:0] obs_now();
        return {ce_pix, hs, vs, hbl, vbl, r, g, b};
    endfunction

    // One clock: check the output due from two steps ago, then drive new inputs.
    task automatic step(input logic ce_i, input logic hs_i, input logic vs_i, input logic hbl_i,
                        input logic vbl_i, input logic [1:0] mode, input logic [23:0] rgb_i,
                        input logic [23:0] exp_rgb, input bit dc);
        exp_t        e;
        exp_t        n;
        logic [28:0] mask;
        logic [28:0] obs;
        @(posedge clk_vid);
        #1;
        if (pipe.size() >= 2) begin
            e    = pipe.pop_front();
            mask = e.dc ? {5'h1f, 24'h0} : {29{1'b1}};
            obs  = obs_now();
            checks++;
            assert ((obs & mask) === (e.v & mask)) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", phase, obs, e.v);
            end
        end
        ce_pix_in  = ce_i;
        hs_in      = hs_i;
        vs_in      = vs_i;
        hbl_in     = hbl_i;
        vbl_in     = vbl_i;
        blend_mode = mode;
        {r_in, g_in, b_in} = rgb_i;
        n.v  = {ce_i, hs_i, vs_i, hbl_i, vbl_i, exp_rgb};
        n.dc = dc;
        pipe.push_back(n);
    endtask

    task automatic hblank(input logic [1:0] mode);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, mode, BLANK_RGB, BLANK_RGB, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, mode, BLANK_RGB, BLANK_RGB, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, mode, BLANK_RGB, BLANK_RGB, 1'b0);
    endtask

    task automatic vblank(input logic [1:0] mode);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, mode, BLANK_RGB, BLANK_RGB, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, mode, BLANK_RGB, BLANK_RGB, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, mode, BLANK_RGB, BLANK_RGB, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, mode, BLANK_RGB, BLANK_RGB, 1'b0);
    endtask

    // Upper half of the frame uses mode_a/exp_a, lower half mode_b/exp_b.
    task automatic frame(input string tag, input logic [23:0] cur, input logic [1:0] mode_a,
                         input logic [23:0] exp_a, input logic [1:0] mode_b,
                         input logic [23:0] exp_b, input int gap);
        phase = tag;
        for (int ln = 0; ln < H; ln++) begin
            for (int px = 0; px < W; px++) begin
                if (ln < H / 2) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mode_a, cur, exp_a, 1'b0);
                else            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mode_b, cur, exp_b, 1'b0);
                for (int gi = 0; gi < gap; gi++)
                    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mode_a, cur, cur, 1'b1);
            end
            hblank((ln < H / 2) ? mode_a : mode_b);
        end
        vblank(mode_b);
    endtask

    task automatic do_reset();
        @(posedge clk_vid);
        #1;
        reset = 1'b1;
        @(posedge clk_vid);
        #1;
        checks++;
        assert (obs_now() === RST_V) else begin
            failures++;
            $error("FAIL reset_outputs observed=%h expected=%h", obs_now(), RST_V);
        end
        checks++;
        assert (dut.hist_q === HIST_EMPTY && dut.addr_q === 16'h0000 && dut.ovf_q === 1'b0) else begin
            failures++;
            $error("FAIL reset_state observed=%0d/%h/%b expected=0/0000/0",
                   dut.hist_q, dut.addr_q, dut.ovf_q);
        end
        reset     = 1'b0;
        ce_pix_in = 1'b0;
        hs_in     = 1'b0;
        vs_in     = 1'b0;
        hbl_in    = 1'b1;
        vbl_in    = 1'b1;
        {r_in, g_in, b_in} = 24'h0;
        pipe.delete();
        pipe.push_back('{v: RST_V, dc: 1'b0});
        pipe.push_back('{v: RST_V, dc: 1'b0});
    endtask

    task automatic check_hist(input string tag, input hist_e expected);
        checks++;
        assert (dut.hist_q === expected) else begin
            failures++;
            $error("FAIL %s hist observed=%0d expected=%0d", tag, dut.hist_q, expected);
        end
    endtask

    initial begin
        // Group 1: fill from EMPTY, then half blend of alternating frames.
        do_reset();
        frame("g1_fill", 24'hFFFFFF, 2'd1, 24'hFFFFFF, 2'd1, 24'hFFFFFF, 0);
        check_hist("g1_after_fill", HIST_VALID);
        frame("g1_half_black", 24'h000000, 2'd1, 24'h808080, 2'd1, 24'h808080, 0);
`ifdef GB_FRAME_BLEND_ACCUM_EN
        frame("g1_half_white", 24'hFFFFFF, 2'd1, 24'hC0C0C0, 2'd1, 24'hC0C0C0, 0);
`else
        frame("g1_half_white", 24'hFFFFFF, 2'd1, 24'h808080, 2'd1, 24'h808080, 0);
`endif

        // Group 2: light/heavy modes, per-channel values, sparse strobe, mid-frame mode change.
        do_reset();
        frame("g2_fill_gap", 24'h00FF40, 2'd2, 24'h00FF40, 2'd2, 24'h00FF40, 1);
        frame("g2_light", 24'hFF0080, 2'd2, 24'hBF4070, 2'd2, 24'hBF4070, 0);
`ifdef GB_FRAME_BLEND_ACCUM_EN
        frame("g2_heavy_half", 24'h00FF40, 2'd3, 24'h8F7064, 2'd1, 24'h60A058, 0);
`else
        frame("g2_heavy_half", 24'h00FF40, 2'd3, 24'hBF4070, 2'd1, 24'h808060, 0);
`endif

        // Group 3: a bypass frame marks history stale for one frame.
        do_reset();
        frame("g3_fill", 24'hFFFFFF, 2'd1, 24'hFFFFFF, 2'd1, 24'hFFFFFF, 0);
        frame("g3_bypass", 24'h000000, 2'd0, 24'h000000, 2'd0, 24'h000000, 0);
        check_hist("g3_after_bypass", HIST_EMPTY);
        frame("g3_refill", 24'hFFFFFF, 2'd1, 24'hFFFFFF, 2'd1, 24'hFFFFFF, 0);
        check_hist("g3_after_refill", HIST_VALID);
        frame("g3_resume", 24'h000000, 2'd1, 24'h808080, 2'd1, 24'h808080, 0);

        // Group 4: address overflow in one oversized frame.
        do_reset();
        phase = "g4_long_line";
        for (int i = 0; i < 65540; i++)
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 24'h000000, 24'h000000, 1'b0);
        hblank(2'd1);
        checks++;
        assert (dut.addr_q === 16'hFFFF && dut.ovf_q === 1'b1) else begin
            failures++;
            $error("FAIL g4_overflow observed=%h/%b expected=ffff/1", dut.addr_q, dut.ovf_q);
        end
        vblank(2'd1);
        check_hist("g4_after_overflow", HIST_EMPTY);
        frame("g4_unblended", 24'hFFFFFF, 2'd1, 24'hFFFFFF, 2'd1, 24'hFFFFFF, 0);
        frame("g4_blend", 24'h000000, 2'd1, 24'h808080, 2'd1, 24'h808080, 0);

        // Group 5: reset in the middle of a line drops blending.
        phase = "g5_pre_reset";
        for (int i = 0; i < 3; i++)
`ifdef GB_FRAME_BLEND_ACCUM_EN
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 24'hFFFFFF, 24'hC0C0C0, 1'b0);
`else
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 24'hFFFFFF, 24'h808080, 1'b0);
`endif
        do_reset();
        phase = "g5_post_reset";
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 24'hFFFFFF, 24'hFFFFFF, 1'b0);
        hblank(2'd1);
        vblank(2'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 24'h0, 24'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 24'h0, 24'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
